vpu_operand_fetch: RTL and testbench

- Parametrised operand-fetch stage between the VPU request FIFO and the vector lanes.
- Accepts one decoded instruction (opcode, up to SRC_CNT source addresses, one destination address) and maps each source address to a bank ID and row address.
- Issues reads to a BANK_CNT-bank SRAM, serialising bank conflicts over multiple rounds, and presents the collected operand bundle downstream on a valid/ready handshake.

---
 rtl/vpu_operand_fetch_if.sv | 37 +++
 rtl/vpu_operand_fetch.sv | 152 +++++++++++++++
 tb/tb_vpu_operand_fetch.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vpu_operand_fetch_if.sv
// Instruction-in / operand-bundle-out bundle for vpu_operand_fetch.
// Slave is the fetch stage itself; master is the request FIFO plus the lane side.
interface vpu_operand_fetch_if #(
    parameter int SRC_CNT      = 3,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 512,
    parameter int OPCODE_WIDTH = 8
);
    localparam int CNT_W = $clog2(SRC_CNT + 1);

    logic                          instr_valid_i;
    logic                          instr_ready_o;
    logic [OPCODE_WIDTH-1:0]       instr_opcode_i;
    logic [CNT_W-1:0]              instr_src_cnt_i;
    logic [SRC_CNT*ADDR_WIDTH-1:0] instr_src_i;
    logic [ADDR_WIDTH-1:0]         instr_dst_i;

    logic                          opnd_valid_o;
    logic                          opnd_ready_i;
    logic [OPCODE_WIDTH-1:0]       opnd_opcode_o;
    logic [ADDR_WIDTH-1:0]         opnd_dst_o;
    logic [SRC_CNT*DATA_WIDTH-1:0] opnd_data_o;

    modport slave (
        input  instr_valid_i, instr_opcode_i, instr_src_cnt_i, instr_src_i, instr_dst_i,
        input  opnd_ready_i,
        output instr_ready_o,
        output opnd_valid_o, opnd_opcode_o, opnd_dst_o, opnd_data_o
    );

    modport master (
        output instr_valid_i, instr_opcode_i, instr_src_cnt_i, instr_src_i, instr_dst_i,
        output opnd_ready_i,
        input  instr_ready_o,
        input  opnd_valid_o, opnd_opcode_o, opnd_dst_o, opnd_data_o
    );
endinterface

// File: rtl/vpu_operand_fetch.sv
// Operand fetch: maps sources to SRAM banks, serialises bank conflicts, returns a bundle (VPU_OPFETCH_SAME_ROW_MERGE_EN merges same-row reads).
// Latency R*(1+RD_LATENCY)+1 cycles for R issue rounds; one instruction in flight, bundle held until opnd_ready_i.
module vpu_operand_fetch #(
    parameter int SRC_CNT      = 3,
    parameter int BANK_CNT     = 4,
    parameter int BANK_DEPTH   = 1024,
    parameter int DATA_WIDTH   = 512,
    parameter int ADDR_WIDTH   = 32,
    parameter int OPCODE_WIDTH = 8,
    parameter int RD_LATENCY   = 1,
    localparam int BANK_LG2    = $clog2(BANK_CNT),
    localparam int ROW_LG2     = $clog2(BANK_DEPTH)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    vpu_operand_fetch_if.slave             io,
    output logic [BANK_CNT-1:0]            sram_rd_en_o,
    output logic [BANK_CNT*ROW_LG2-1:0]    sram_rd_addr_o,
    input  logic [BANK_CNT*DATA_WIDTH-1:0] sram_rd_data_i,
    output logic [15:0]                    conflict_cnt_o
);
    localparam int OFS_LG2 = $clog2(DATA_WIDTH / 8);
    localparam int WAIT_W  = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

    state_t                  state_q, state_n;
    logic                    rdy_q;
    logic [OPCODE_WIDTH-1:0] opcode_q;
    logic [ADDR_WIDTH-1:0]   dst_q;
    logic [BANK_LG2-1:0]     src_bank_q [SRC_CNT];
    logic [ROW_LG2-1:0]      src_row_q  [SRC_CNT];
    logic [SRC_CNT-1:0]      pending_q, grant_q, grant, init_mask;
    logic [DATA_WIDTH-1:0]   opnd_q     [SRC_CNT];
    logic [DATA_WIDTH-1:0]   rd_data    [BANK_CNT];
    logic [15:0]             conflict_q;
    logic [WAIT_W-1:0]       wait_q;
    logic                    wait_last, accept;
    logic [BANK_CNT-1:0]     rd_en;
    logic [ROW_LG2-1:0]      rd_row     [BANK_CNT];
    logic                    unused_src;

    assign accept     = io.instr_valid_i & rdy_q;
    assign wait_last  = (wait_q == WAIT_W'(RD_LATENCY - 1));
    assign unused_src = ^io.instr_src_i;

    always_comb begin
        init_mask = '0;
        for (int i = 0; i < SRC_CNT; i++)
            init_mask[i] = (i < int'(io.instr_src_cnt_i));
    end

    // Slots are scanned in index order, so each bank goes to its lowest pending slot.
    always_comb begin
        rd_en = '0;
        grant = '0;
        for (int b = 0; b < BANK_CNT; b++) rd_row[b] = '0;
        if (state_q == ISSUE) begin
            for (int i = 0; i < SRC_CNT; i++) begin
                if (pending_q[i]) begin
                    if (!rd_en[src_bank_q[i]]) begin
                        rd_en[src_bank_q[i]]  = 1'b1;
                        rd_row[src_bank_q[i]] = src_row_q[i];
                        grant[i]              = 1'b1;
                    end
`ifdef VPU_OPFETCH_SAME_ROW_MERGE_EN
                    else if (rd_row[src_bank_q[i]] == src_row_q[i]) begin
                        grant[i] = 1'b1;
                    end
`endif
                end
            end
        end
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE:    if (accept) state_n = (|init_mask) ? ISSUE : OUT;
            ISSUE:   state_n = WAIT;
            WAIT:    if (wait_last) state_n = (|pending_q) ? ISSUE : OUT;
            OUT:     if (io.opnd_ready_i) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rdy_q      <= 1'b0;
            opcode_q   <= '0;
            dst_q      <= '0;
            pending_q  <= '0;
            grant_q    <= '0;
            conflict_q <= '0;
            wait_q     <= '0;
            for (int i = 0; i < SRC_CNT; i++) begin
                src_bank_q[i] <= '0;
                src_row_q[i]  <= '0;
                opnd_q[i]     <= '0;
            end
        end else begin
            state_q <= state_n;
            // Ready is a flop so it stays low while reset is asserted.
            rdy_q   <= (state_n == IDLE);
            case (state_q)
                IDLE: if (accept) begin
                    opcode_q  <= io.instr_opcode_i;
                    dst_q     <= io.instr_dst_i;
                    pending_q <= init_mask;
                    grant_q   <= '0;
                    for (int i = 0; i < SRC_CNT; i++) begin
                        src_bank_q[i] <= io.instr_src_i[i*ADDR_WIDTH + OFS_LG2 +: BANK_LG2];
                        src_row_q[i]  <= io.instr_src_i[i*ADDR_WIDTH + OFS_LG2 + BANK_LG2 +: ROW_LG2];
                        opnd_q[i]     <= '0;
                    end
                end
                ISSUE: begin
                    pending_q <= pending_q & ~grant;
                    grant_q   <= grant;
                    wait_q    <= '0;
                    if ((|(pending_q & ~grant)) && (conflict_q != 16'hFFFF))
                        conflict_q <= conflict_q + 16'd1;
                end
                WAIT: begin
                    wait_q <= wait_q + 1'b1;
                    if (wait_last) begin
                        for (int i = 0; i < SRC_CNT; i++)
                            if (grant_q[i]) opnd_q[i] <= rd_data[src_bank_q[i]];
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar b = 0; b < BANK_CNT; b++) begin : g_bank
        assign rd_data[b] = sram_rd_data_i[b*DATA_WIDTH +: DATA_WIDTH];
        assign sram_rd_addr_o[b*ROW_LG2 +: ROW_LG2] = rd_row[b];
    end

    for (genvar i = 0; i < SRC_CNT; i++) begin : g_slot
        assign io.opnd_data_o[i*DATA_WIDTH +: DATA_WIDTH] = opnd_q[i];
    end

    assign sram_rd_en_o     = rd_en;
    assign conflict_cnt_o   = conflict_q;
    assign io.instr_ready_o = rdy_q;
    assign io.opnd_valid_o  = (state_q == OUT);
    assign io.opnd_opcode_o = opcode_q;
    assign io.opnd_dst_o    = dst_q;
endmodule

// File: tb/tb_vpu_operand_fetch.sv
// Directed bench for vpu_operand_fetch with a one-cycle-latency banked SRAM model.
module tb_vpu_operand_fetch;
    localparam int SRC_CNT = 3;
    localparam int BANK_CNT = 4;
    localparam int DW = 512;
    localparam int RW = 10;

    logic                   clk;
    logic                   rst_n;
    logic [BANK_CNT-1:0]    sram_rd_en;
    logic [BANK_CNT*RW-1:0] sram_rd_addr;
    logic [BANK_CNT*DW-1:0] sram_rd_data;
    logic [15:0]            conflict_cnt;

    int n_chk;
    int n_fail;
    int cc_exp;
    logic [BANK_CNT+BANK_CNT*RW-1:0] iss_q [$];

    vpu_operand_fetch_if #(.SRC_CNT(SRC_CNT), .ADDR_WIDTH(32), .DATA_WIDTH(DW), .OPCODE_WIDTH(8)) ifc ();

    vpu_operand_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .io             (ifc),
        .sram_rd_en_o   (sram_rd_en),
        .sram_rd_addr_o (sram_rd_addr),
        .sram_rd_data_i (sram_rd_data),
        .conflict_cnt_o (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] row_data(input int b, input int row);
        logic [31:0] w;
        w = 32'hB000_0000 | (32'(b) << 16) | 32'(row);
        return {16{w}};
    endfunction

    always @(posedge clk) begin
        for (int b = 0; b < BANK_CNT; b++)
            if (sram_rd_en[b]) sram_rd_data[b*DW +: DW] <= row_data(b, int'(sram_rd_addr[b*RW +: RW]));
    end

    always @(negedge clk) begin
        if (sram_rd_en != '0) iss_q.push_back({sram_rd_en, sram_rd_addr});
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] slot(input int i);
        return ifc.opnd_data_o[i*DW +: DW];
    endfunction

    task automatic send(input logic [1:0] cnt, input logic [31:0] a0, input logic [31:0] a1,
                        input logic [31:0] a2, input logic [7:0] op, input logic [31:0] dst);
        bit acc;
        acc = 0;
        iss_q.delete();
        ifc.instr_valid_i   = 1'b1;
        ifc.instr_src_cnt_i = cnt;
        ifc.instr_src_i     = {a2, a1, a0};
        ifc.instr_opcode_i  = op;
        ifc.instr_dst_i     = dst;
        for (int k = 0; k < 20; k++) begin
            if (ifc.instr_ready_o) begin
                @(posedge clk);
                acc = 1;
                break;
            end
            @(negedge clk);
        end
        if (!acc) check("accept_timeout", 0, 1);
        @(negedge clk);
        ifc.instr_valid_i = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!ifc.opnd_valid_o && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!ifc.opnd_valid_o) check("valid_timeout", 0, 1);
    endtask

    task automatic drain();
        ifc.opnd_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ifc.opnd_ready_i = 1'b0;
    endtask

    initial begin
        int lat;
        int rounds_exp;
        int lat_exp;
        logic [DW-1:0] snap;
        bit stable;

        n_chk = 0;
        n_fail = 0;
        cc_exp = 0;
        sram_rd_data = '0;
        rst_n = 1'b0;
        ifc.instr_valid_i = 1'b0;
        ifc.instr_src_cnt_i = '0;
        ifc.instr_src_i = '0;
        ifc.instr_opcode_i = '0;
        ifc.instr_dst_i = '0;
        ifc.opnd_ready_i = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_instr_ready", 64'(ifc.instr_ready_o), 0);
        check("rst_opnd_valid", 64'(ifc.opnd_valid_o), 0);
        check("rst_rd_en", 64'(sram_rd_en), 0);
        check("rst_conflict", 64'(conflict_cnt), 0);
        check("rst_data_zero", 64'(ifc.opnd_data_o == '0), 1);
        check("rst_opcode_dst", {ifc.opnd_dst_o, 24'b0, ifc.opnd_opcode_o}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ready", 64'(ifc.instr_ready_o), 1);

        // Distinct banks 0,1,2
        send(2'd3, 32'h000, 32'h040, 32'h080, 8'h11, 32'hD0);
        wait_valid(lat);
        check("distinct_lat", 64'(lat), 3);
        check("distinct_rounds", 64'(iss_q.size()), 1);
        if (iss_q.size() > 0) check("distinct_rd", 64'(iss_q[0]), {4'b0111, 40'd0});
        check("distinct_s0", 64'(slot(0) == row_data(0, 0)), 1);
        check("distinct_s1", 64'(slot(1) == row_data(1, 0)), 1);
        check("distinct_s2", 64'(slot(2) == row_data(2, 0)), 1);
        check("distinct_op", 64'(ifc.opnd_opcode_o), 64'h11);
        check("distinct_dst", 64'(ifc.opnd_dst_o), 64'hD0);
        check("distinct_cc", 64'(conflict_cnt), 0);
        check("out_not_ready", 64'(ifc.instr_ready_o), 0);
        drain();

        // Full conflict on bank 0, rows 0,1,2
        send(2'd3, 32'h000, 32'h100, 32'h200, 8'h12, 32'hD1);
        wait_valid(lat);
        cc_exp = 2;
        check("full_lat", 64'(lat), 7);
        check("full_rounds", 64'(iss_q.size()), 3);
        for (int r = 0; r < 3 && r < iss_q.size(); r++)
            check("full_rd", 64'(iss_q[r]), {4'b0001, 40'(r)});
        for (int i = 0; i < 3; i++)
            check("full_slot", 64'(slot(i) == row_data(0, i)), 1);
        check("full_cc", 64'(conflict_cnt), 64'(cc_exp));
        drain();

        // Same bank+row pair plus bank 3
`ifdef VPU_OPFETCH_SAME_ROW_MERGE_EN
        rounds_exp = 1;
        lat_exp = 3;
`else
        rounds_exp = 2;
        lat_exp = 5;
        cc_exp = cc_exp + 1;
`endif
        send(2'd3, 32'h140, 32'h140, 32'h0C0, 8'h13, 32'hD2);
        wait_valid(lat);
        check("merge_lat", 64'(lat), 64'(lat_exp));
        check("merge_rounds", 64'(iss_q.size()), 64'(rounds_exp));
        if (iss_q.size() > 0) check("merge_rd0", 64'(iss_q[0]), {4'b1010, 40'd1 << 10});
        check("merge_s0", 64'(slot(0) == row_data(1, 1)), 1);
        check("merge_s1", 64'(slot(1) == row_data(1, 1)), 1);
        check("merge_s2", 64'(slot(2) == row_data(3, 0)), 1);
        check("merge_cc", 64'(conflict_cnt), 64'(cc_exp));
        drain();

        // Only slot 0 valid
        send(2'd1, 32'h0C0, 32'h140, 32'h200, 8'h14, 32'hD3);
        wait_valid(lat);
        check("partial_lat", 64'(lat), 3);
        check("partial_rounds", 64'(iss_q.size()), 1);
        if (iss_q.size() > 0) check("partial_rd", 64'(iss_q[0]), {4'b1000, 40'd0});
        check("partial_s0", 64'(slot(0) == row_data(3, 0)), 1);
        check("partial_s1_zero", 64'(slot(1) == '0), 1);
        check("partial_s2_zero", 64'(slot(2) == '0), 1);
        drain();

        // Backpressure then back-to-back
        send(2'd3, 32'h000, 32'h040, 32'h080, 8'h22, 32'hD4);
        wait_valid(lat);
        snap = slot(1);
        stable = 1;
        repeat (5) begin
            @(negedge clk);
            if (!ifc.opnd_valid_o || slot(1) != snap || ifc.instr_ready_o || ifc.opnd_opcode_o != 8'h22)
                stable = 0;
        end
        check("bp_stable", 64'(stable), 1);
        check("bp_data", 64'(snap == row_data(1, 0)), 1);
        ifc.opnd_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ifc.opnd_ready_i = 1'b0;
        check("bp_ready_after", 64'(ifc.instr_ready_o), 1);
        check("bp_valid_after", 64'(ifc.opnd_valid_o), 0);
        send(2'd0, 32'h040, 32'h080, 32'h0C0, 8'h33, 32'h44);
        wait_valid(lat);
        check("b2b_lat", 64'(lat), 1);
        check("b2b_rounds", 64'(iss_q.size()), 0);
        check("b2b_op", 64'(ifc.opnd_opcode_o), 64'h33);
        check("b2b_zero", 64'(ifc.opnd_data_o == '0), 1);
        drain();

        // Reset during WAIT of a full-conflict instruction
        send(2'd3, 32'h000, 32'h100, 32'h200, 8'h55, 32'hD5);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rd_en", 64'(sram_rd_en), 0);
        check("mid_rst_valid", 64'(ifc.opnd_valid_o), 0);
        check("mid_rst_ready", 64'(ifc.instr_ready_o), 0);
        check("mid_rst_cc", 64'(conflict_cnt), 0);
        check("mid_rst_data", 64'(ifc.opnd_data_o == '0), 1);
        iss_q.delete();
        repeat (3) @(negedge clk);
        check("mid_rst_no_issue", 64'(iss_q.size()), 0);
        rst_n = 1'b1;
        @(negedge clk);

        send(2'd3, 32'h000, 32'h040, 32'h080, 8'h66, 32'hD6);
        wait_valid(lat);
        check("post_rst_lat", 64'(lat), 3);
        check("post_rst_s0", 64'(slot(0) == row_data(0, 0)), 1);
        check("post_rst_s2", 64'(slot(2) == row_data(2, 0)), 1);
        check("post_rst_cc", 64'(conflict_cnt), 0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
